// File: rtl/brk_pkg.sv
// Shared types and constants for the breakpoint halt controller.
// Pure definitions: no logic, no latency, no flow control.
package brk_pkg;

   localparam int BRK_PASSW = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      HALTREQ = 2'd2,
      HALTED  = 2'd3
   } brkstate_t;

endpackage

// File: rtl/brk_halt_ctl_if.sv
// Comparator / console / CPU signal bundle around the halt controller.
// master drives the stimulus side, slave is the controller itself.
interface brk_halt_ctl_if
   import brk_pkg::*;
#(
   parameter int PASSW = BRK_PASSW
);
   logic             brHALT;
   logic [0:35]      cpuADDR;
   logic             cpuHALTED;
   logic             cslENABLE;
   logic [PASSW-1:0] cslPASS;
   logic             cslLOAD;
   logic             cslCONT;
   logic             brHALTREQ;
   logic [0:35]      brADDR;
   logic [PASSW-1:0] brPASSCNT;
   logic [PASSW-1:0] brHITCNT;
   logic [1:0]       brSTATE;

   modport master (
      output brHALT, cpuADDR, cpuHALTED, cslENABLE, cslPASS, cslLOAD, cslCONT,
      input  brHALTREQ, brADDR, brPASSCNT, brHITCNT, brSTATE
   );

   modport slave (
      input  brHALT, cpuADDR, cpuHALTED, cslENABLE, cslPASS, cslLOAD, cslCONT,
      output brHALTREQ, brADDR, brPASSCNT, brHITCNT, brSTATE
   );
endinterface

// File: rtl/brk_halt_ctl.sv
// Pass-counted breakpoint halt: holds a level halt request until the CPU reports halted.
// All outputs registered, 1 clock after cause; no backpressure, the brHALT pulse is never stalled.
module brk_halt_ctl
   import brk_pkg::*;
#(
   parameter int PASSW = BRK_PASSW
)(
   input  logic           clk,
   input  logic           rst,
   brk_halt_ctl_if.slave  bus
);

   brkstate_t        state_q,   state_d;
   logic             haltreq_q, haltreq_d;
   logic [0:35]      addr_q,    addr_d;
   logic [PASSW-1:0] pass_q,    pass_d;
   logic [PASSW-1:0] hit_q,     hit_d;

   function automatic logic [PASSW-1:0] sat_inc(input logic [PASSW-1:0] v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      pass_d  = pass_q;
      hit_d   = hit_q;

      if (state_q == IDLE) begin
         pass_d = bus.cslPASS;
         hit_d  = '0;
         if (bus.cslENABLE) state_d = ARMED;
      end else if (!bus.cslENABLE) begin
         // Disarm beats every other event; counters and capture are frozen.
         state_d = IDLE;
      end else begin
         unique case (state_q)
            ARMED: begin
               if (bus.brHALT) hit_d = sat_inc(hit_q);
               // A coincident reload swallows the match: no decrement, no halt.
               if (bus.cslLOAD) begin
                  pass_d = bus.cslPASS;
               end else if (bus.brHALT) begin
                  if (pass_q == '0) begin
                     addr_d  = bus.cpuADDR;
                     state_d = HALTREQ;
                  end else begin
                     pass_d = pass_q - 1'b1;
                  end
               end
            end
            HALTREQ: begin
               if (bus.cpuHALTED) state_d = HALTED;
            end
            HALTED: begin
               if (bus.cslCONT) begin
                  pass_d  = bus.cslPASS;
                  state_d = ARMED;
               end else if (bus.cslLOAD) begin
                  pass_d = bus.cslPASS;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      haltreq_d = (state_d == HALTREQ);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         haltreq_q <= 1'b0;
         addr_q    <= '0;
         pass_q    <= '0;
         hit_q     <= '0;
      end else begin
         state_q   <= state_d;
         haltreq_q <= haltreq_d;
         addr_q    <= addr_d;
         pass_q    <= pass_d;
         hit_q     <= hit_d;
      end
   end

   assign bus.brHALTREQ = haltreq_q;
   assign bus.brADDR    = addr_q;
   assign bus.brPASSCNT = pass_q;
   assign bus.brHITCNT  = hit_q;
   assign bus.brSTATE   = state_q;

endmodule

// File: tb/tb_brk_halt_ctl.sv
// Directed-vector bench for brk_halt_ctl; expected values are hand-computed constants.
module tb_brk_halt_ctl;
   import brk_pkg::*;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_miss;

   brk_halt_ctl_if #(.PASSW(BRK_PASSW)) bus ();

   brk_halt_ctl #(.PASSW(BRK_PASSW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %h, want %h", tag, obs, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are checked there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [35:0] a4;

   initial begin
      n_vec  = 0;
      n_miss = 0;
      rst              = 1'b0;
      bus.brHALT       = 1'b0;
      bus.cpuADDR      = '0;
      bus.cpuHALTED    = 1'b0;
      bus.cslENABLE    = 1'b0;
      bus.cslPASS      = '0;
      bus.cslLOAD      = 1'b0;
      bus.cslCONT      = 1'b0;
      tick();
      chk("rst_state",   36'(bus.brSTATE),   36'd0);
      chk("rst_haltreq", 36'(bus.brHALTREQ), 36'd0);
      chk("rst_addr",    36'(bus.brADDR),    36'd0);
      chk("rst_pass",    36'(bus.brPASSCNT), 36'd0);
      chk("rst_hit",     36'(bus.brHITCNT),  36'd0);
      rst = 1'b1;

      // 1: arm at pass=0, first match halts
      bus.cslENABLE = 1'b1;
      tick();
      chk("arm_state", 36'(bus.brSTATE),   36'd1);
      chk("arm_pass",  36'(bus.brPASSCNT), 36'd0);
      bus.brHALT  = 1'b1;
      bus.cpuADDR = 36'o040000_001000;
      tick();
      bus.brHALT = 1'b0;
      chk("t1_haltreq", 36'(bus.brHALTREQ), 36'd1);
      chk("t1_addr",    36'(bus.brADDR),    36'o040000_001000);
      chk("t1_hit",     36'(bus.brHITCNT),  36'd1);
      chk("t1_state",   36'(bus.brSTATE),   36'd2);

      // 3: halt handshake and continue with reload to 3
      bus.cpuHALTED = 1'b1;
      tick();
      bus.cpuHALTED = 1'b0;
      chk("t3_state_halted", 36'(bus.brSTATE),   36'd3);
      chk("t3_haltreq_low",  36'(bus.brHALTREQ), 36'd0);
      bus.cslPASS = 16'd3;
      bus.cslCONT = 1'b1;
      tick();
      bus.cslCONT = 1'b0;
      chk("t3_state_armed", 36'(bus.brSTATE),   36'd1);
      chk("t3_pass_reload", 36'(bus.brPASSCNT), 36'd3);

      // 2: four matches with pass=3, halt only on the fourth
      for (int i = 0; i < 4; i++) begin
         bus.brHALT  = 1'b1;
         bus.cpuADDR = 36'o000100_000000 + 36'(i);
         tick();
         if (i < 3) begin
            chk("t2_pass",    36'(bus.brPASSCNT), 36'(2 - i));
            chk("t2_nohalt",  36'(bus.brHALTREQ), 36'd0);
         end
      end
      bus.brHALT = 1'b0;
      a4 = 36'o000100_000003;
      chk("t2_haltreq", 36'(bus.brHALTREQ), 36'd1);
      chk("t2_addr",    36'(bus.brADDR),    a4);
      chk("t2_pass0",   36'(bus.brPASSCNT), 36'd0);
      chk("t2_hit",     36'(bus.brHITCNT),  36'd5);

      // matches and loads during HALTREQ are ignored
      bus.brHALT  = 1'b1;
      bus.cpuADDR = 36'o777777_777777;
      bus.cslLOAD = 1'b1;
      bus.cslPASS = 16'd9;
      tick();
      bus.brHALT  = 1'b0;
      bus.cslLOAD = 1'b0;
      chk("hr_ign_hit",   36'(bus.brHITCNT),  36'd5);
      chk("hr_ign_addr",  36'(bus.brADDR),    a4);
      chk("hr_ign_pass",  36'(bus.brPASSCNT), 36'd0);
      chk("hr_ign_state", 36'(bus.brSTATE),   36'd2);

      // halted, continue with pass 0
      bus.cpuHALTED = 1'b1;
      tick();
      bus.cpuHALTED = 1'b0;
      bus.cslPASS = 16'd0;
      bus.cslCONT = 1'b1;
      tick();
      bus.cslCONT = 1'b0;
      chk("cont_state", 36'(bus.brSTATE), 36'd1);

      // 4: load coinciding with match at pass 0
      bus.cslLOAD = 1'b1;
      bus.cslPASS = 16'd5;
      bus.brHALT  = 1'b1;
      tick();
      bus.cslLOAD = 1'b0;
      bus.brHALT  = 1'b0;
      chk("t4_state",   36'(bus.brSTATE),   36'd1);
      chk("t4_nohalt",  36'(bus.brHALTREQ), 36'd0);
      chk("t4_pass",    36'(bus.brPASSCNT), 36'd5);
      chk("t4_hit",     36'(bus.brHITCNT),  36'd6);
      bus.cslLOAD = 1'b1;
      bus.cslPASS = 16'd0;
      tick();
      bus.cslLOAD = 1'b0;
      bus.brHALT  = 1'b1;
      tick();
      bus.brHALT = 1'b0;
      chk("t4_haltreq", 36'(bus.brHALTREQ), 36'd1);
      bus.cslENABLE = 1'b0;
      tick();
      chk("t4_dis_state",   36'(bus.brSTATE),   36'd0);
      chk("t4_dis_haltreq", 36'(bus.brHALTREQ), 36'd0);
      chk("t4_dis_hitheld", 36'(bus.brHITCNT),  36'd7);
      tick();
      chk("t4_idle_hitclr", 36'(bus.brHITCNT),  36'd0);

      // 5: saturate the hit counter via load-masked matches
      bus.cslENABLE = 1'b1;
      tick();
      bus.cslLOAD = 1'b1;
      bus.brHALT  = 1'b1;
      repeat (65535) tick();
      chk("t5_hit_full", 36'(bus.brHITCNT), 36'hFFFF);
      tick();
      chk("t5_hit_sat",  36'(bus.brHITCNT), 36'hFFFF);
      chk("t5_state",    36'(bus.brSTATE),  36'd1);
      bus.cslLOAD = 1'b0;
      bus.cpuADDR = 36'o123456_701234;
      tick();
      bus.brHALT = 1'b0;
      chk("t5_haltreq", 36'(bus.brHALTREQ), 36'd1);
      chk("t5_addr",    36'(bus.brADDR),    36'o123456_701234);

      // asynchronous reset mid-request, away from any clock edge
      #2;
      rst = 1'b0;
      #1;
      chk("ar_haltreq", 36'(bus.brHALTREQ), 36'd0);
      chk("ar_state",   36'(bus.brSTATE),   36'd0);
      chk("ar_addr",    36'(bus.brADDR),    36'd0);
      chk("ar_pass",    36'(bus.brPASSCNT), 36'd0);
      chk("ar_hit",     36'(bus.brHITCNT),  36'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
